// File: rtl/priority_enc_4_2_v_always.sv
// Registered 4-to-2 priority encoder: bit 3 wins, one-cycle latency, valid flag.
// Async active-low reset clears the output registers.
module priority_enc_4_2_v_always (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic [3:0] i_code,
  output logic [1:0] o_code,
  output logic       o_valid
);

  logic [1:0] code_next;
  logic       valid_next;

  always_comb begin
    code_next  = '0;
    valid_next = 1'b1;
    if (i_code[3])      code_next = 2'b11;
    else if (i_code[2]) code_next = 2'b10;
    else if (i_code[1]) code_next = 2'b01;
    else if (i_code[0]) code_next = 2'b00;
    else                valid_next = 1'b0;
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_code  <= '0;
      o_valid <= 1'b0;
    end else begin
      o_code  <= code_next;
      o_valid <= valid_next;
    end
  end

endmodule

// File: tb/tb_priority_enc_4_2_v_always.sv
// Directed and random checks of the registered priority encoder against a
// highest-set-bit model computed arithmetically.
module tb_priority_enc_4_2_v_always;

  logic       i_clk;
  logic       i_rst_n;
  logic [3:0] i_code;
  logic [1:0] o_code;
  logic       o_valid;

  int errors;
  int checks;

  priority_enc_4_2_v_always dut (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_code  (i_code),
    .o_code  (o_code),
    .o_valid (o_valid)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  // {code, valid}: index of the highest set bit is floor(log2(v)).
  function automatic logic [2:0] model(input logic [3:0] v);
    int n;
    int idx;
    n = int'(v);
    if (n == 0) return 3'b000;
    idx = $clog2(n + 1) - 1;
    return {idx[1:0], 1'b1};
  endfunction

  task automatic check(input string tag, input logic [1:0] exp_code, input logic exp_valid);
    checks++;
    assert ({o_code, o_valid} === {exp_code, exp_valid})
    else begin
      errors++;
      $error("FAIL %s: got code=%b valid=%b, expected code=%b valid=%b",
             tag, o_code, o_valid, exp_code, exp_valid);
    end
  endtask

  // Drive a value, let one rising edge capture it, sample 1 time unit later.
  task automatic apply(input string tag, input logic [3:0] v);
    logic [2:0] e;
    i_code = v;
    @(posedge i_clk);
    #1;
    e = model(v);
    check(tag, e[2:1], e[0]);
  endtask

  initial begin
    logic [3:0] r;
    errors  = 0;
    checks  = 0;
    i_rst_n = 1'b0;
    i_code  = 4'b1111;

    // Reset holds outputs clear while the input is nonzero.
    #1;
    check("reset_async", 2'b00, 1'b0);
    repeat (2) @(posedge i_clk);
    #1;
    check("reset_hold", 2'b00, 1'b0);
    #2 i_rst_n = 1'b1;
    #1;
    check("reset_release_preedge", 2'b00, 1'b0);

    // Exhaustive sweep 0..15 then wrap to 0, 1.
    for (int i = 0; i < 18; i++) apply("sweep", 4'(i % 16));

    // Priority masking.
    apply("mask_1001", 4'b1001);
    check("mask_1001_const", 2'b11, 1'b1);
    apply("mask_0011", 4'b0011);
    check("mask_0011_const", 2'b01, 1'b1);
    apply("mask_0110", 4'b0110);
    check("mask_0110_const", 2'b10, 1'b1);

    // Async reset mid-cycle with outputs at 11/1.
    apply("pre_reset", 4'b1000);
    check("pre_reset_const", 2'b11, 1'b1);
    #2 i_rst_n = 1'b0;
    #1;
    check("async_assert", 2'b00, 1'b0);
    repeat (2) begin
      @(posedge i_clk);
      #1;
      check("async_hold_1000", 2'b00, 1'b0);
    end

    // Release with 0100 applied: outputs stay clear until the next edge.
    i_code = 4'b0100;
    #2 i_rst_n = 1'b1;
    #1;
    check("release_wait", 2'b00, 1'b0);
    @(posedge i_clk);
    #1;
    check("release_first", 2'b10, 1'b1);

    // Reset mid-stream discards the in-flight value.
    i_code = 4'b1111;
    #1 i_rst_n = 1'b0;
    @(posedge i_clk);
    #1;
    check("midstream_discard", 2'b00, 1'b0);
    #2 i_rst_n = 1'b1;
    apply("post_reset", 4'b0010);

    // Glitch isolation: toggles between edges are invisible.
    apply("glitch_base", 4'b0100);
    i_code = 4'b0001;
    #1 i_code = 4'b1000;
    #1;
    check("glitch_between", 2'b10, 1'b1);
    i_code = 4'b0001;
    @(posedge i_clk);
    #1;
    check("glitch_edge", 2'b00, 1'b1);

    // Back-to-back alternation.
    for (int i = 0; i < 8; i++) begin
      apply("alternate", (i % 2 == 0) ? 4'b0000 : 4'b1000);
      if (i % 2 == 0) check("alternate_const", 2'b00, 1'b0);
      else            check("alternate_const", 2'b11, 1'b1);
    end

    // Random stream.
    for (int i = 0; i < 200; i++) begin
      r = 4'($urandom_range(0, 15));
      apply("random", r);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not complete, expected finish");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/priority_enc_4_2_v_always.md
PRIORITY_ENC_4_2_V_ALWAYS -- requirements
Module: priority_enc_4_2_v_always

Interface
REQ-001 The module SHALL have no parameters; all widths are fixed as listed below.
REQ-002 i_clk  input  1  single clock; all state updates on rising edge.
REQ-003 i_rst_n  input  1  reset, asynchronous assert, active-low.
REQ-004 i_code  input  4  request vector; bit 3 = highest priority, bit 0 = lowest.
REQ-005 o_code  output  2  binary index of highest-priority asserted bit of i_code.
REQ-006 o_valid  output  1  high when at least one i_code bit was asserted.
REQ-007 o_code and o_valid SHALL be driven directly from flip-flops, with no combinational path from any input to any output.

Function
REQ-008 The encode SHALL be priority-based on the highest set bit:
- i_code[3]=1 -> o_code=2'b11
- else i_code[2]=1 -> 2'b10
- else i_code[1]=1 -> 2'b01
- else i_code[0]=1 -> 2'b00
REQ-009 Lower-priority bits SHALL be don't-care whenever a higher bit is set; for example, 4'b1111 -> 2'b11 and 4'b0110 -> 2'b10.
REQ-010 For i_code=4'b0000, the outputs SHALL be o_code=2'b00 and o_valid=0.
REQ-011 For any nonzero i_code, o_valid SHALL be 1.
REQ-012 Latency SHALL be exactly 1 clock: i_code sampled at rising edge N SHALL appear on the outputs after edge N and hold until edge N+1.
REQ-013 A new i_code value SHALL be accepted every cycle, with no handshake and no stall.
REQ-014 Input changes between clock edges SHALL NOT affect the outputs until the next rising edge.
REQ-015 o_code and o_valid SHALL always update together on the same edge and never be mutually inconsistent.
REQ-016 The logic SHALL be fully specified for all 16 input values: no latches and no X propagation from a known input.
REQ-017 An X or Z on i_code is outside the specification; the design has no requirement to detect it.

Reset
REQ-018 Asserting i_rst_n=0 SHALL immediately (asynchronously) force o_code=2'b00 and o_valid=0, regardless of the clock.
REQ-019 While i_rst_n=0, the outputs SHALL hold their reset values, and i_code SHALL be ignored.
REQ-020 Deassertion of i_rst_n SHALL be synchronous to i_clk; the first i_code capture SHALL occur at the first rising edge with i_rst_n=1.
REQ-021 Reset asserted mid-stream SHALL discard the in-flight value; after release, the outputs SHALL reflect only post-reset samples.

Verification
REQ-022 Exhaustive sweep: apply i_code=0..15 once per clock, then wrap to 0 and 1 (18 vectors total) -> each output is 1 cycle later and matches:
- 0 -> 00/0
- 1 -> 00/1
- 2-3 -> 01/1
- 4-7 -> 10/1
- 8-15 -> 11/1
REQ-023 Priority masking: 4'b1001 -> o_code=11; 4'b0011 -> o_code=01; o_valid=1 in both cases.
REQ-024 Async reset: with outputs at 11/1, drop i_rst_n between clock edges -> outputs go to 00/0 before the next edge and hold while reset stays low, even with i_code=4'b1000.
REQ-025 Reset release: release i_rst_n with i_code=4'b0100 applied -> outputs stay 00/0 until the first rising edge after release, then read 10/1.
REQ-026 Glitch isolation: toggle i_code 4'b0001 -> 4'b1000 -> 4'b0001 entirely between two edges -> outputs change only at the edge and reflect the value present at that edge (00/1).
REQ-027 Back-to-back transitions: apply 4'b0000 and 4'b1000 on alternating cycles -> o_valid toggles 0/1 every cycle and o_code alternates 00/11, each 1 cycle delayed.
